// File: rtl/dbg_trace_capture.sv
// Debug trace capture: records the selected debug word into a circular buffer
// once armed, stops a programmable number of samples after a masked trigger.
module dbg_trace_capture #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] din,
  input  logic          arm,
  input  logic [DW-1:0] trig_val,
  input  logic [DW-1:0] trig_mask,
  input  logic [AW-1:0] post_cnt,
  input  logic          rd_en,
  output logic          rd_vld,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic [1:0]    state,
  output logic [AW:0]   fill,
  output logic [AW-1:0] trig_pos
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_F_C = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A_C = AW'(1);

  logic [DW-1:0] mem_r [DEPTH];
  state_e        state_r, state_nxt_s;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, post_lat_r, post_cnt_r, trig_pos_r;
  logic [AW:0]   fill_r, rem_r;
  logic          rd_vld_r, rd_last_r;
  logic [DW-1:0] rd_data_r;

  logic          trig_hit_s, wr_en_s, rd_ok_s, load_post_s, done_entry_s;
  logic [AW:0]   fill_inc_s, tp_full_s;
  logic [AW-1:0] wr_ptr_inc_s;

  assign trig_hit_s   = (((din ^ trig_val) & trig_mask) == {DW{1'b0}});
  assign fill_inc_s   = (fill_r == FULL_C) ? fill_r : (fill_r + ONE_F_C);
  assign wr_ptr_inc_s = wr_ptr_r + ONE_A_C;
  // Trigger index counted from the oldest entry of the final window
  assign tp_full_s    = fill_inc_s - ONE_F_C - {1'b0, post_lat_r};

  assign state    = state_r;
  assign fill     = fill_r;
  assign trig_pos = trig_pos_r;
  assign rd_vld   = rd_vld_r;
  assign rd_data  = rd_data_r;
  assign rd_last  = rd_last_r;

  // Next-state and per-cycle strobes; arm overrides everything
  always_comb begin
    state_nxt_s  = state_r;
    wr_en_s      = 1'b0;
    rd_ok_s      = 1'b0;
    load_post_s  = 1'b0;
    done_entry_s = 1'b0;
    if (arm) begin
      state_nxt_s = ST_PRE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_PRE: begin
          wr_en_s = 1'b1;
          if (trig_hit_s) begin
            if (post_lat_r == {AW{1'b0}}) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_POST;
              load_post_s = 1'b1;
            end
          end else begin
            state_nxt_s = ST_PRE;
          end
        end
        ST_POST: begin
          wr_en_s = 1'b1;
          if (post_cnt_r == ONE_A_C) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_POST;
          end
        end
        ST_DONE: rd_ok_s = rd_en && (rem_r != {(AW+1){1'b0}});
        default: state_nxt_s = ST_IDLE;
      endcase
      done_entry_s = wr_en_s && (state_nxt_s == ST_DONE);
    end
  end

  // Control state, pointers, counters and registered read port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      post_lat_r <= {AW{1'b0}};
      post_cnt_r <= {AW{1'b0}};
      trig_pos_r <= {AW{1'b0}};
      fill_r     <= {(AW+1){1'b0}};
      rem_r      <= {(AW+1){1'b0}};
      rd_vld_r   <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= {DW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      rd_vld_r  <= rd_ok_s;
      rd_last_r <= rd_ok_s && (rem_r == ONE_F_C);
      if (rd_ok_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + ONE_A_C;
        rem_r     <= rem_r - ONE_F_C;
      end
      if (arm) begin
        wr_ptr_r   <= {AW{1'b0}};
        fill_r     <= {(AW+1){1'b0}};
        rem_r      <= {(AW+1){1'b0}};
        post_lat_r <= post_cnt;
        post_cnt_r <= {AW{1'b0}};
        trig_pos_r <= {AW{1'b0}};
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_inc_s;
          fill_r   <= fill_inc_s;
        end
        if (load_post_s) begin
          post_cnt_r <= post_lat_r;
        end else if (state_r == ST_POST) begin
          post_cnt_r <= post_cnt_r - ONE_A_C;
        end
        if (done_entry_s) begin
          trig_pos_r <= tp_full_s[AW-1:0];
          rd_ptr_r   <= wr_ptr_inc_s - fill_inc_s[AW-1:0];
          rem_r      <= fill_inc_s;
        end
      end
    end
  end

  // Sample storage; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: tb/tb_dbg_trace_capture.sv
// Scenario bench for dbg_trace_capture: expected read entries are queued when
// rd_en is driven and checked by a monitor when rd_vld appears.
module tb_dbg_trace_capture;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] din;
  logic       arm;
  logic [7:0] trig_val;
  logic [7:0] trig_mask;
  logic [3:0] post_cnt;
  logic       rd_en;
  logic       rd_vld;
  logic [7:0] rd_data;
  logic       rd_last;
  logic [1:0] state;
  logic [4:0] fill;
  logic [3:0] trig_pos;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] sb_q[$];

  dbg_trace_capture #(.DEPTH(16), .AW(4), .DW(8)) dut (
    .clk(clk), .rstn(rstn), .din(din), .arm(arm), .trig_val(trig_val),
    .trig_mask(trig_mask), .post_cnt(post_cnt), .rd_en(rd_en),
    .rd_vld(rd_vld), .rd_data(rd_data), .rd_last(rd_last),
    .state(state), .fill(fill), .trig_pos(trig_pos)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every rd_vld must match the oldest queued expectation
  always @(negedge clk) begin
    if (rstn === 1'b1 && rd_vld === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rd_vld with data=%h last=%b, none expected", rd_data, rd_last);
      end else begin
        logic [8:0] exp;
        exp = sb_q.pop_front();
        if ({rd_last, rd_data} !== exp) begin
          n_fail++;
          $display("FAIL sb_entry: got data=%h last=%b, expected data=%h last=%b",
                   rd_data, rd_last, exp[7:0], exp[8]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; arm = 1'b1; rd_en = 1'b1; din = 8'h00;
    trig_val = 8'h00; trig_mask = 8'h00; post_cnt = 4'd0;
    step(); step();
    n_tests++;
    if ({state, fill, trig_pos, rd_vld, rd_data} !== {2'd0, 5'd0, 4'd0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset: state=%0d fill=%0d trig_pos=%0d rd_vld=%b rd_data=%h, expected all 0",
               state, fill, trig_pos, rd_vld, rd_data);
    end
    arm = 1'b0; rd_en = 1'b0; rstn = 1'b1;
    step();
    n_tests++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_hold: state=%0d expected 0", state);
    end
  endtask

  task automatic test_wrap();
    trig_val = 8'h20; trig_mask = 8'hFF; post_cnt = 4'd3;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i <= 8'h23; i++) begin
      din = 8'(i);
      step();
      if (i == 8'h22) begin
        n_tests++;
        if (state !== 2'd2) begin
          n_fail++;
          $display("FAIL wrap_post: state=%0d expected 2", state);
        end
      end
    end
    n_tests++;
    if ({state, fill, trig_pos} !== {2'd3, 5'd16, 4'd12}) begin
      n_fail++;
      $display("FAIL wrap_done: state=%0d fill=%0d trig_pos=%0d, expected 3/16/12", state, fill, trig_pos);
    end
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back({(i == 15), 8'(8'h14 + i)});
      rd_en = 1'b1;
      step();
      n_tests++;
      if (rd_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_b2b: read %0d rd_vld=%b expected 1", i, rd_vld);
      end
    end
    rd_en = 1'b0;
    step();
    n_tests++;
    if (sb_q.size() != 0 || rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_drain: pending=%0d rd_vld=%b, expected 0/0", sb_q.size(), rd_vld);
    end
  endtask

  task automatic test_early();
    trig_val = 8'h05; trig_mask = 8'hFF; post_cnt = 4'd2;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h05 + i);
      step();
    end
    din = 8'h08;
    n_tests++;
    if ({state, fill, trig_pos} !== {2'd3, 5'd3, 4'd0}) begin
      n_fail++;
      $display("FAIL early_done: state=%0d fill=%0d trig_pos=%0d, expected 3/3/0", state, fill, trig_pos);
    end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back({(i == 2), 8'(8'h05 + i)});
      rd_en = 1'b1;
      step();
    end
    step();
    n_tests++;
    if (rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL early_empty: 4th read rd_vld=%b expected 0", rd_vld);
    end
    rd_en = 1'b0;
    step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL early_drain: pending=%0d expected 0", sb_q.size());
    end
  endtask

  task automatic test_mask();
    trig_val = 8'h30; trig_mask = 8'hF0; post_cnt = 4'd0;
    arm = 1'b1; step(); arm = 1'b0;
    din = 8'h2F; step();
    n_tests++;
    if ({state, fill} !== {2'd1, 5'd1}) begin
      n_fail++;
      $display("FAIL mask_nohit: state=%0d fill=%0d, expected 1/1", state, fill);
    end
    din = 8'h3A; step();
    n_tests++;
    if ({state, fill, trig_pos} !== {2'd3, 5'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL mask_done: state=%0d fill=%0d trig_pos=%0d, expected 3/2/1", state, fill, trig_pos);
    end
    sb_q.push_back({1'b0, 8'h2F});
    sb_q.push_back({1'b1, 8'h3A});
    rd_en = 1'b1; step(); step();
    rd_en = 1'b0; step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL mask_drain: pending=%0d expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_post();
    trig_val = 8'h40; trig_mask = 8'hFF; post_cnt = 4'd8;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'h40 + i);
      step();
    end
    n_tests++;
    if ({state, fill} !== {2'd2, 5'd4}) begin
      n_fail++;
      $display("FAIL rpost_mid: state=%0d fill=%0d, expected 2/4", state, fill);
    end
    rstn = 1'b0; step(); rstn = 1'b1;
    n_tests++;
    if ({state, fill, rd_vld} !== {2'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rpost_reset: state=%0d fill=%0d rd_vld=%b, expected 0/0/0", state, fill, rd_vld);
    end
    trig_val = 8'hEE;
    arm = 1'b1; step(); arm = 1'b0;
    n_tests++;
    if ({state, fill} !== {2'd1, 5'd0}) begin
      n_fail++;
      $display("FAIL rpost_rearm: state=%0d fill=%0d, expected 1/0", state, fill);
    end
    for (int i = 1; i <= 3; i++) begin
      din = 8'(i);
      step();
      n_tests++;
      if (fill !== 5'(i)) begin
        n_fail++;
        $display("FAIL rpost_fill: fill=%0d expected %0d", fill, i);
      end
    end
  endtask

  task automatic test_arm_priority();
    trig_mask = 8'h00; post_cnt = 4'd0;
    arm = 1'b1; step(); arm = 1'b0;
    din = 8'h55; step();
    n_tests++;
    if ({state, fill, trig_pos} !== {2'd3, 5'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL prio_done: state=%0d fill=%0d trig_pos=%0d, expected 3/1/0", state, fill, trig_pos);
    end
    trig_val = 8'h62; trig_mask = 8'hFF; post_cnt = 4'd1;
    arm = 1'b1; rd_en = 1'b1; step(); arm = 1'b0; rd_en = 1'b0;
    n_tests++;
    if ({state, fill, rd_vld} !== {2'd1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_arm: state=%0d fill=%0d rd_vld=%b, expected 1/0/0", state, fill, rd_vld);
    end
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'h60 + i);
      step();
    end
    n_tests++;
    if ({state, fill, trig_pos} !== {2'd3, 5'd4, 4'd2}) begin
      n_fail++;
      $display("FAIL prio_recap: state=%0d fill=%0d trig_pos=%0d, expected 3/4/2", state, fill, trig_pos);
    end
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back({(i == 3), 8'(8'h60 + i)});
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0; step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL prio_drain: pending=%0d expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_early();
    test_mask();
    test_reset_post();
    test_arm_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
